// File: rtl/hgcal_pkg.sv
// Shared constants and types for the HGCAL autoencoder front end.
// The default thresholds here are also used by the bench's reference quantiser.
package hgcal_pkg;

  localparam int Q_W = 2;

  typedef logic [Q_W-1:0] code_t;

  localparam int DEF_NUM_IN = 48;
  localparam int DEF_IN_W   = 8;

  localparam int unsigned DEF_THR1 = 16;
  localparam int unsigned DEF_THR2 = 64;
  localparam int unsigned DEF_THR3 = 160;

endpackage

// File: rtl/hgcal_input_packer_if.sv
// Generic valid/ready stream used for both the sample input and the packed frame output.
// The master drives valid/data/last; the slave answers with ready.
interface hgcal_input_packer_if #(
  parameter int DATA_W = 8
);

  logic              valid;
  logic              ready;
  logic              last;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/hgcal_quant.sv
// Combinational 2-bit threshold quantiser for one unsigned sample.
module hgcal_quant
  import hgcal_pkg::*;
#(
  parameter int          IN_W = DEF_IN_W,
  parameter int unsigned THR1 = DEF_THR1,
  parameter int unsigned THR2 = DEF_THR2,
  parameter int unsigned THR3 = DEF_THR3
) (
  input  logic [IN_W-1:0] sample,
  output code_t           code
);

  localparam logic [IN_W-1:0] T1 = IN_W'(THR1);
  localparam logic [IN_W-1:0] T2 = IN_W'(THR2);
  localparam logic [IN_W-1:0] T3 = IN_W'(THR3);

  always_comb begin
    code = code_t'(0);
    if (sample >= T3) begin
      code = code_t'(3);
    end else if (sample >= T2) begin
      code = code_t'(2);
    end else if (sample >= T1) begin
      code = code_t'(1);
    end
  end

endmodule

// File: rtl/hgcal_input_packer.sv
// Packs NUM_IN quantised samples into one frame vector for the first LUT layer.
// Assembly and output registers are separate so ingest overlaps a pending frame.
module hgcal_input_packer
  import hgcal_pkg::*;
#(
  parameter int          NUM_IN = DEF_NUM_IN,
  parameter int          IN_W   = DEF_IN_W,
  parameter int unsigned THR1   = DEF_THR1,
  parameter int unsigned THR2   = DEF_THR2,
  parameter int unsigned THR3   = DEF_THR3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  hgcal_input_packer_if.slave    s_if,
  hgcal_input_packer_if.master   m_if,
  output logic                   err,
  output logic [15:0]            frame_cnt
);

  localparam int IDX_W = $clog2(NUM_IN);
  localparam int OUT_W = Q_W * NUM_IN;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

  if (NUM_IN < 2) begin : g_bad_num_in
    $error("hgcal_input_packer: NUM_IN must be at least 2");
  end
  if (!((THR1 < THR2) && (THR2 < THR3) && (64'(THR3) < (64'd1 << IN_W)))) begin : g_bad_thr
    $error("hgcal_input_packer: thresholds must satisfy THR1<THR2<THR3<2^IN_W");
  end

  code_t             code;
  logic              last_beat;
  logic              accept;
  logic              out_hs;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [OUT_W-1:0]  asm_q, asm_d;
  logic [OUT_W-1:0]  m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              err_q, err_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  hgcal_quant #(
    .IN_W (IN_W),
    .THR1 (THR1),
    .THR2 (THR2),
    .THR3 (THR3)
  ) u_quant (
    .sample (s_if.data),
    .code   (code)
  );

  // Only a completing beat can stall, and only if it would clobber an unconsumed frame.
  assign last_beat   = (idx_q == LAST_IDX);
  assign s_if.ready  = !(last_beat && m_valid_q && !m_if.ready);
  assign accept      = s_if.valid && s_if.ready;
  assign out_hs      = m_valid_q && m_if.ready;

  assign m_if.valid  = m_valid_q;
  assign m_if.data   = m_data_q;
  assign m_if.last   = 1'b1;
  assign err         = err_q;
  assign frame_cnt   = frame_cnt_q;

  always_comb begin
    idx_d       = idx_q;
    asm_d       = asm_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;

    if (out_hs) begin
      m_valid_d   = 1'b0;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    // A completion in the same cycle as a handshake re-asserts valid with the new frame.
    if (accept) begin
      asm_d[Q_W*int'(idx_q) +: Q_W] = code;
      if (last_beat) begin
        m_data_d  = asm_d;
        m_valid_d = 1'b1;
        idx_d     = '0;
        if (!s_if.last) begin
          err_d = 1'b1;
        end
      end else if (s_if.last) begin
        err_d = 1'b1;
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      asm_q       <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_hgcal_input_packer.sv
// Directed bench for hgcal_input_packer with a queue of expected frames.
module tb_hgcal_input_packer;
  import hgcal_pkg::*;

  localparam int NUM_IN = 48;
  localparam int IN_W   = 8;
  localparam int DW     = 2 * NUM_IN;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        err;
  logic [15:0] frame_cnt;

  hgcal_input_packer_if #(.DATA_W(IN_W)) s_if ();
  hgcal_input_packer_if #(.DATA_W(DW))   m_if ();

  hgcal_input_packer #(
    .NUM_IN (NUM_IN),
    .IN_W   (IN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_if      (s_if),
    .m_if      (m_if),
    .err       (err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int              checks   = 0;
  int              failures = 0;
  logic [DW-1:0]   expQ[$];
  logic [DW-1:0]   mAsm;
  int              mIdx;
  bit              mErr;
  logic [15:0]     mCnt;
  logic [IN_W-1:0] smp[NUM_IN];
  int              bnd[7]   = '{15, 16, 63, 64, 159, 160, 255};
  int              bcode[7] = '{0, 1, 1, 2, 2, 3, 3};

  function automatic logic [1:0] refCode(input logic [IN_W-1:0] s);
    if (int'(s) >= int'(DEF_THR3)) return 2'd3;
    if (int'(s) >= int'(DEF_THR2)) return 2'd2;
    if (int'(s) >= int'(DEF_THR1)) return 2'd1;
    return 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares every visible output against the model; returns the ready the model expects.
  task automatic checkOutput(input bit mr, output bit expReady);
    expReady = !((mIdx == NUM_IN - 1) && (expQ.size() != 0) && !mr);
    chk("s_ready", DW'(s_if.ready), DW'(expReady));
    chk("m_valid", DW'(m_if.valid), DW'(expQ.size() != 0));
    chk("err", DW'(err), DW'(mErr));
    chk("frame_cnt", DW'(frame_cnt), DW'(mCnt));
    if (expQ.size() != 0) chk("m_data", m_if.data, expQ[0]);
  endtask

  task automatic applyStimulus(input bit v, input logic [IN_W-1:0] d, input bit l,
                               input bit mr, output bit acc);
    bit expReady;
    bit hs;
    @(negedge clk);
    s_if.valid = v;
    s_if.data  = d;
    s_if.last  = l;
    m_if.ready = mr;
    #1;
    checkOutput(mr, expReady);
    hs  = (expQ.size() != 0) && mr;
    acc = v && expReady;
    @(posedge clk);
    if (hs) begin
      expQ.delete(0);
      mCnt++;
    end
    if (acc) begin
      mAsm[2*mIdx +: 2] = refCode(d);
      if (mIdx == NUM_IN - 1) begin
        expQ.push_back(mAsm);
        if (!l) mErr = 1'b1;
        mIdx = 0;
      end else if (l) begin
        mErr = 1'b1;
        mIdx = 0;
      end else begin
        mIdx++;
      end
    end
  endtask

  task automatic idle(input bit mr);
    bit acc;
    applyStimulus(1'b0, '0, 1'b0, mr, acc);
  endtask

  task automatic sendFrame(input int n, input int lastAt, input bit mr);
    bit acc;
    int tries;
    for (int i = 0; i < n; i++) begin
      tries = 0;
      do begin
        applyStimulus(1'b1, smp[i], i == lastAt, mr, acc);
        tries++;
      end while (!acc && tries < 100);
      if (!acc) begin
        checks++;
        failures++;
        $error("[TB] FAIL accept_timeout beat=%0d observed=stalled expected=accepted", i);
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    expQ.delete();
    mIdx = 0;
    mErr = 1'b0;
    mCnt = '0;
    mAsm = '0;
    chk("rst_m_valid", DW'(m_if.valid), DW'(0));
    chk("rst_s_ready", DW'(s_if.ready), DW'(1));
    chk("rst_err", DW'(err), DW'(0));
    chk("rst_frame_cnt", DW'(frame_cnt), DW'(0));
    chk("rst_m_data", m_if.data, '0);
    @(negedge clk);
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    rst_n      = 1'b1;
  endtask

  task automatic randomFrame();
    for (int i = 0; i < NUM_IN; i++) smp[i] = IN_W'($urandom_range(0, 255));
  endtask

  initial begin
    bit acc;
    rst_n      = 1'b1;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.last  = 1'b0;
    m_if.ready = 1'b0;
    mIdx = 0;
    mErr = 1'b0;
    mCnt = '0;
    mAsm = '0;

    doReset();

    // Quantiser boundaries in the first seven slots, held at the output for inspection.
    for (int i = 0; i < NUM_IN; i++) smp[i] = (i < 7) ? IN_W'(bnd[i]) : IN_W'(i * 5);
    sendFrame(NUM_IN, NUM_IN - 1, 1'b0);
    idle(1'b0);
    #1;
    for (int j = 0; j < 7; j++) chk("quant_boundary", DW'(m_if.data[2*j +: 2]), DW'(bcode[j]));
    idle(1'b1);

    for (int i = 0; i < NUM_IN; i++) smp[i] = IN_W'(i * 5);
    sendFrame(NUM_IN, NUM_IN - 1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    #1;
    chk("frame_cnt_single", DW'(frame_cnt), DW'(2));

    for (int f = 0; f < 4; f++) begin
      randomFrame();
      sendFrame(NUM_IN, NUM_IN - 1, 1'b1);
    end
    idle(1'b1);
    idle(1'b1);
    #1;
    chk("frame_cnt_b2b", DW'(frame_cnt), DW'(6));

    // Backpressure: frame 1 pending, frame 2 stalls on its last beat until release.
    randomFrame();
    sendFrame(NUM_IN, NUM_IN - 1, 1'b0);
    randomFrame();
    sendFrame(NUM_IN - 1, -1, 1'b0);
    applyStimulus(1'b1, smp[NUM_IN-1], 1'b1, 1'b0, acc);
    applyStimulus(1'b1, smp[NUM_IN-1], 1'b1, 1'b0, acc);
    applyStimulus(1'b1, smp[NUM_IN-1], 1'b1, 1'b1, acc);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    randomFrame();
    sendFrame(11, 10, 1'b1);
    idle(1'b1);
    #1;
    chk("err_early_last", DW'(err), DW'(1));
    randomFrame();
    sendFrame(NUM_IN, NUM_IN - 1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    randomFrame();
    sendFrame(NUM_IN, -1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    randomFrame();
    sendFrame(NUM_IN, NUM_IN - 1, 1'b0);
    randomFrame();
    sendFrame(20, -1, 1'b0);
    doReset();
    randomFrame();
    sendFrame(NUM_IN, NUM_IN - 1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    #1;
    chk("frame_cnt_after_reset", DW'(frame_cnt), DW'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
